reg_file_modport: RTL and testbench
===================================

Name: reg_file_modport

Overview:
- 32-entry x DATA_WIDTH MIPS architectural register file for the decode stage.
- Two asynchronous read ports (rs, rt) and one synchronous write port from write-back.
- Whole-array snapshot restore for branch-misprediction recovery, plus a full-array export for snapshot capture.
- Sits between decoder/write-back and the checkpoint logic; flat-port equivalent of the reg_file_output_ifc, decoder_output_ifc and write_back_ifc usage.

Parameters:
- DATA_WIDTH, 32, register width in bits.
- NUM_REGS, 32, number of architectural registers.
- ADDR_WIDTH, 5, register address width (log2 NUM_REGS).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  synchronous active-low reset.
- uses_rs  input  1  decoder: rs operand valid.
- rs_addr  input  ADDR_WIDTH  decoder: rs index.
- uses_rt  input  1  decoder: rt operand valid.
- rt_addr  input  ADDR_WIDTH  decoder: rt index.
- wb_uses_rw  input  1  write-back: write enable.
- wb_rw_addr  input  ADDR_WIDTH  write-back: destination index.
- wb_rw_data  input  DATA_WIDTH  write-back: write data.
- rs_data  output  DATA_WIDTH  rs read data.
- rt_data  output  DATA_WIDTH  rt read data.
- recover_snapshot  input  1  load entire array from regs_snapshot this edge.
- recovery_done_ack  input  1  reserved; accepted, no effect.
- regs_snapshot  input  NUM_REGS x DATA_WIDTH  unpacked array of restore values.
- regs_out  output  NUM_REGS x DATA_WIDTH  live copy of all registers.
- done  output  1  restore-complete flag.

Behaviour:
- Reset: while rst_n=0 at posedge, all registers <= 0 and done <= 0. Reset has priority over recovery and write.
- Reads are combinational from current register contents:
  - rs_data = uses_rs ? regs[rs_addr] : 0
  - rt_data = uses_rt ? regs[rt_addr] : 0
- No write-to-read bypass: a same-cycle read of the register being written returns the old value; the new value is visible the cycle after the edge.
- Register 0 is hardwired to zero:
  - writes with wb_rw_addr=0 are ignored;
  - restore forces reg0 to 0 regardless of regs_snapshot[0];
  - reading reg0 returns 0.
- Write: if rst_n=1, recover_snapshot=0 and wb_uses_rw=1, then regs[wb_rw_addr] <= wb_rw_data at posedge.
- Recovery: if rst_n=1 and recover_snapshot=1, all registers 1..NUM_REGS-1 <= regs_snapshot[i] at posedge and done <= 1.
  - A simultaneous write-back in the same cycle is dropped entirely (recovery wins).
- done tracks recover_snapshot with one cycle of latency:
  - high on the cycle after every cycle with recover_snapshot=1;
  - 0 otherwise, giving a 1-cycle pulse for a 1-cycle request.
- regs_out continuously mirrors the register array, reflecting updates the cycle after the edge.
- recovery_done_ack does not alter any state.
- No X propagation: every register has a defined value after the first reset.

Decomposition:
- mips_core_pkg holds DATA_WIDTH, NUM_REGS and ADDR_WIDTH plus the typedef reg_array_t (NUM_REGS x DATA_WIDTH unpacked), used for regs_snapshot and regs_out.
- One optional sub-module, reg_file_bank, containing the storage array, write/restore priority mux and reset. The top adds the read muxes with the uses_* gating and the done flop.

Test Plan:
- Reset then read: rst_n=0 for 2 cycles; uses_rs=1, rs_addr=5 -> rs_data=0, done=0, regs_out all 0.
- Write/readback: write r7=0xDEADBEEF. Same cycle rt_addr=7 -> old value 0; next cycle -> 0xDEADBEEF; with uses_rt=0 -> rt_data=0.
- r0 protection: write r0=0x12345678 -> reading r0 returns 0 and regs_out[0]=0.
- Snapshot restore: regs_snapshot[i]=0x1000+i, recover_snapshot=1 for one cycle -> next cycle regs_out[i]=0x1000+i for i>0, regs_out[0]=0, done=1; following cycle done=0.
- Restore vs write collision: recover_snapshot=1 and wb write r3=0xFFFF in the same cycle -> r3 = snapshot value 0x1003.
- Reset mid-recovery: rst_n=0 together with recover_snapshot=1 -> all registers 0, done=0.

Source files
------------

// File: rtl/mips_core_pkg.sv
// mips_core_pkg: shared register-file sizing and the whole-array type used for snapshot capture/restore.
package mips_core_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_REGS   = 32;
  localparam int ADDR_WIDTH = $clog2(NUM_REGS);
  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef word_t reg_array_t [NUM_REGS];
endpackage

// File: rtl/reg_file_modport_bank.sv
// reg_file_bank: architectural register storage with restore-over-write priority and r0 tied to zero.
module reg_file_bank
  import mips_core_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  addr_t      waddr,
  input  word_t      wdata,
  input  logic       restore,
  input  reg_array_t snapshot,
  output reg_array_t regs
);
  reg_array_t regs_d, regs_q;
  always_comb begin
    regs_d = regs_q;
    if (restore) begin
      for (int i = 1; i < NUM_REGS; i++) regs_d[i] = snapshot[i];
    end else if (we) begin
      regs_d[waddr] = wdata;
    end
    regs_d[0] = '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) regs_q <= '{default: '0};
    else regs_q <= regs_d;
  end
  assign regs = regs_q;
endmodule

// File: rtl/reg_file_modport.sv
// reg_file_modport: decode-stage register file with gated async reads, write-back port and snapshot restore.
module reg_file_modport
  import mips_core_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uses_rs,
  input  addr_t      rs_addr,
  input  logic       uses_rt,
  input  addr_t      rt_addr,
  input  logic       wb_uses_rw,
  input  addr_t      wb_rw_addr,
  input  word_t      wb_rw_data,
  output word_t      rs_data,
  output word_t      rt_data,
  input  logic       recover_snapshot,
  input  logic       recovery_done_ack,
  input  reg_array_t regs_snapshot,
  output reg_array_t regs_out,
  output logic       done
);
  reg_array_t regs;
  logic done_d, done_q;
  logic unused_ack;
  reg_file_bank u_bank (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (wb_uses_rw),
    .waddr    (wb_rw_addr),
    .wdata    (wb_rw_data),
    .restore  (recover_snapshot),
    .snapshot (regs_snapshot),
    .regs     (regs)
  );
  // The acknowledge is reserved by the pipeline protocol and deliberately ignored.
  assign unused_ack = recovery_done_ack;
  always_comb begin
    done_d  = recover_snapshot;
    rs_data = uses_rs ? regs[rs_addr] : '0;
    rt_data = uses_rt ? regs[rt_addr] : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) done_q <= 1'b0;
    else done_q <= done_d;
  end
  assign done     = done_q;
  assign regs_out = regs;
endmodule

// File: tb/tb_reg_file_modport.sv
// tb_reg_file_modport: directed plus randomized checks of reg_file_modport against an array model.
module tb_reg_file_modport;
  import mips_core_pkg::*;
  logic clk = 1'b0;
  logic rst_n, uses_rs, uses_rt, wb_uses_rw, recover_snapshot, recovery_done_ack, done;
  addr_t rs_addr, rt_addr, wb_rw_addr;
  word_t wb_rw_data, rs_data, rt_data;
  reg_array_t regs_snapshot, regs_out;
  word_t m [NUM_REGS];
  logic m_done;
  int passed = 0, total = 0, fails = 0;

  reg_file_modport dut (
    .clk(clk), .rst_n(rst_n), .uses_rs(uses_rs), .rs_addr(rs_addr), .uses_rt(uses_rt),
    .rt_addr(rt_addr), .wb_uses_rw(wb_uses_rw), .wb_rw_addr(wb_rw_addr), .wb_rw_data(wb_rw_data),
    .rs_data(rs_data), .rt_data(rt_data), .recover_snapshot(recover_snapshot),
    .recovery_done_ack(recovery_done_ack), .regs_snapshot(regs_snapshot), .regs_out(regs_out),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input word_t obs, input word_t exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    #1;
    chk("rs_data", rs_data, uses_rs ? m[rs_addr] : '0);
    chk("rt_data", rt_data, uses_rt ? m[rt_addr] : '0);
    chk("done", word_t'(done), word_t'(m_done));
    for (int i = 0; i < NUM_REGS; i++) chk($sformatf("regs_out[%0d]", i), regs_out[i], m[i]);
  endtask

  // Architectural rules: reset clears, recovery loads r1..rN-1 and drops the write, r0 never changes.
  task automatic tick();
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) m[i] = '0;
      m_done = 1'b0;
    end else begin
      m_done = recover_snapshot;
      if (recover_snapshot) for (int i = 1; i < NUM_REGS; i++) m[i] = regs_snapshot[i];
      else if (wb_uses_rw && wb_rw_addr != 0) m[wb_rw_addr] = wb_rw_data;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < NUM_REGS; i++) begin
      m[i] = 'x;
      regs_snapshot[i] = '0;
    end
    m_done = 1'bx;
    rst_n = 1'b0; uses_rs = 1'b1; rs_addr = 5; uses_rt = 1'b0; rt_addr = 0;
    wb_uses_rw = 1'b0; wb_rw_addr = 0; wb_rw_data = '0;
    recover_snapshot = 1'b0; recovery_done_ack = 1'b0;
    tick();
    tick();
    check_all();
    chk("reset_rs5", rs_data, '0);
    chk("reset_done", word_t'(done), '0);
    rst_n = 1'b1;
    tick();
    wb_uses_rw = 1'b1; wb_rw_addr = 7; wb_rw_data = 32'hDEADBEEF; uses_rt = 1'b1; rt_addr = 7;
    #1;
    chk("no_bypass_r7", rt_data, '0);
    tick();
    wb_uses_rw = 1'b0;
    #1;
    chk("readback_r7", rt_data, 32'hDEADBEEF);
    uses_rt = 1'b0;
    #1;
    chk("gated_rt", rt_data, '0);
    check_all();
    wb_uses_rw = 1'b1; wb_rw_addr = 0; wb_rw_data = 32'h12345678;
    tick();
    wb_uses_rw = 1'b0; uses_rs = 1'b1; rs_addr = 0;
    #1;
    chk("r0_read", rs_data, '0);
    chk("r0_regs_out", regs_out[0], '0);
    for (int i = 0; i < NUM_REGS; i++) regs_snapshot[i] = 32'h1000 + i;
    recover_snapshot = 1'b1; wb_uses_rw = 1'b1; wb_rw_addr = 3; wb_rw_data = 32'hFFFF;
    tick();
    recover_snapshot = 1'b0; wb_uses_rw = 1'b0;
    #1;
    chk("restore_r3_wins", regs_out[3], 32'h1003);
    chk("restore_r31", regs_out[31], 32'h101F);
    chk("restore_r0", regs_out[0], '0);
    chk("restore_done_hi", word_t'(done), 32'd1);
    check_all();
    tick();
    chk("restore_done_lo", word_t'(done), '0);
    for (int n = 0; n < 300; n++) begin
      uses_rs = 1'($urandom); rs_addr = addr_t'($urandom); uses_rt = 1'($urandom); rt_addr = addr_t'($urandom);
      wb_uses_rw = ($urandom_range(0, 3) != 0); wb_rw_addr = addr_t'($urandom); wb_rw_data = $urandom;
      recover_snapshot = ($urandom_range(0, 15) == 0); recovery_done_ack = 1'($urandom);
      if (recover_snapshot) for (int i = 0; i < NUM_REGS; i++) regs_snapshot[i] = $urandom;
      check_all();
      tick();
    end
    recover_snapshot = 1'b0; wb_uses_rw = 1'b0;
    check_all();
    rst_n = 1'b0; recover_snapshot = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) regs_snapshot[i] = 32'hA5A5_0000 + i;
    tick();
    chk("rst_recover_done", word_t'(done), '0);
    chk("rst_recover_r9", regs_out[9], '0);
    check_all();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
